// File: rtl/pwm_duty_selector.sv
// pwm_duty_selector: button-stepped, saturating PWM duty setting with period-aligned duty updates.
// Auto-repeat on a long press is compiled in only when PWM_SEL_AUTOREPEAT_EN is defined.
module pwm_duty_selector #(
    parameter int PWM_BITS    = 8,
    parameter int DUTY_STEP   = 32,
    parameter int REPEAT_DLY  = 1000,
    parameter int REPEAT_RATE = 200
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                EN_Selector,
    input  logic                dir,
    output logic [PWM_BITS-1:0] duty,
    output logic                pwm_out,
    output logic                period_tick
);
    localparam logic [PWM_BITS-1:0] CNT_LAST  = {{(PWM_BITS-1){1'b1}}, 1'b0};
    localparam logic [PWM_BITS:0]   STEP      = (PWM_BITS+1)'(DUTY_STEP);
    localparam int                  HW        = $clog2(REPEAT_DLY + 1);
    localparam logic [HW-1:0]       HOLD_LAST = HW'(REPEAT_DLY - 1);
`ifdef PWM_SEL_AUTOREPEAT_EN
    localparam int                  RW        = $clog2(REPEAT_RATE + 1);
    localparam logic [RW-1:0]       RATE_LAST = RW'(REPEAT_RATE - 1);
`endif

    typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_e;

    state_e              state_q, state_d;
    logic                btn_q;
    logic [HW-1:0]       hold_q, hold_d;
`ifdef PWM_SEL_AUTOREPEAT_EN
    logic [RW-1:0]       rep_q, rep_d;
`endif
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic [PWM_BITS-1:0] duty_active_q, duty_active_d;
    logic [PWM_BITS-1:0] cnt_q, cnt_d;
    logic                pwm_q, pwm_d;
    logic                press, step, wrap;
    logic [PWM_BITS:0]   sum, diff;

    assign press = EN_Selector && !btn_q;
    assign wrap  = cnt_q == CNT_LAST;

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (press) state_d = HOLD;
            HOLD: begin
                if (!EN_Selector) state_d = IDLE;
`ifdef PWM_SEL_AUTOREPEAT_EN
                else if (hold_q == HOLD_LAST) state_d = REPEAT;
`endif
            end
            REPEAT:  if (!EN_Selector) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Steps fire on the press edge, on HOLD->REPEAT entry, then every REPEAT_RATE cycles.
    always_comb begin
        step   = 1'b0;
        hold_d = '0;
`ifdef PWM_SEL_AUTOREPEAT_EN
        rep_d  = '0;
`endif
        case (state_q)
            IDLE: step = press;
            HOLD: begin
                hold_d = (hold_q == HOLD_LAST) ? hold_q : hold_q + 1'b1;
`ifdef PWM_SEL_AUTOREPEAT_EN
                step   = EN_Selector && hold_q == HOLD_LAST;
`endif
            end
`ifdef PWM_SEL_AUTOREPEAT_EN
            REPEAT: begin
                rep_d = (rep_q == RATE_LAST) ? '0 : rep_q + 1'b1;
                step  = EN_Selector && rep_q == RATE_LAST;
            end
`endif
            default: ;
        endcase
    end

    // One extra bit catches carry/borrow so the duty saturates instead of wrapping.
    always_comb begin
        sum           = {1'b0, duty_q} + STEP;
        diff          = {1'b0, duty_q} - STEP;
        duty_d        = !step ? duty_q
                      : dir   ? (diff[PWM_BITS] ? '0 : diff[PWM_BITS-1:0])
                      :         (sum[PWM_BITS]  ? '1 : sum[PWM_BITS-1:0]);
        cnt_d         = wrap ? '0 : cnt_q + 1'b1;
        duty_active_d = wrap ? duty_q : duty_active_q;
        pwm_d         = cnt_q < duty_active_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            btn_q         <= 1'b1;
            hold_q        <= '0;
`ifdef PWM_SEL_AUTOREPEAT_EN
            rep_q         <= '0;
`endif
            duty_q        <= '0;
            duty_active_q <= '0;
            cnt_q         <= '0;
            pwm_q         <= 1'b0;
        end else begin
            btn_q         <= EN_Selector;
            hold_q        <= hold_d;
`ifdef PWM_SEL_AUTOREPEAT_EN
            rep_q         <= rep_d;
`endif
            duty_q        <= duty_d;
            duty_active_q <= duty_active_d;
            cnt_q         <= cnt_d;
            pwm_q         <= pwm_d;
        end
    end

    assign duty        = duty_q;
    assign pwm_out     = pwm_q;
    assign period_tick = wrap;
endmodule
